// File: rtl/reg_cmd_pkg.sv
// rtl/reg_cmd_pkg.sv - shared command codes, FSM states and request record for the register command arbiter
package reg_cmd_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RD   = 2'b01;
  localparam logic [1:0] WR   = 2'b10;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic is_bus_cmd(input logic [1:0] c);
    return (c == RD) || (c == WR);
  endfunction

endpackage

// File: rtl/reg_cmd_arbiter_if.sv
// rtl/reg_cmd_arbiter_if.sv - requester, response and register-bus signals of the command arbiter
interface reg_cmd_arbiter_if;

  logic        req0_valid, req1_valid;
  logic [1:0]  req0_cmd, req1_cmd;
  logic [7:0]  req0_addr, req1_addr;
  logic [31:0] req0_wdata, req1_wdata;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        rsp0_err, rsp1_err;
  logic [1:0]  cmd;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data_w;
  logic [31:0] cmd_data_r;

  modport master (
    output req0_valid, req0_cmd, req0_addr, req0_wdata,
    output req1_valid, req1_cmd, req1_addr, req1_wdata,
    output cmd_data_r,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp0_err,
    input  rsp1_valid, rsp1_rdata, rsp1_err,
    input  cmd, cmd_addr, cmd_data_w
  );

  modport slave (
    input  req0_valid, req0_cmd, req0_addr, req0_wdata,
    input  req1_valid, req1_cmd, req1_addr, req1_wdata,
    input  cmd_data_r,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp0_err,
    output rsp1_valid, rsp1_rdata, rsp1_err,
    output cmd, cmd_addr, cmd_data_w
  );

endinterface

// File: rtl/reg_cmd_rr_arb.sv
// rtl/reg_cmd_rr_arb.sv - 2-way grant logic; REG_CMD_ARB_RR_EN selects round-robin, else port 0 fixed priority
module reg_cmd_rr_arb (
`ifdef REG_CMD_ARB_RR_EN
  input  logic       clk,
  input  logic       rstn,
  input  logic       take,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef REG_CMD_ARB_RR_EN
  // prio set means port 1 wins the next contention
  logic prio;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || !prio))
      gnt[0] = 1'b1;
    else if (req[1])
      gnt[1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn)
      prio <= 1'b0;
    else if (take)
      prio <= gnt[0];
  end
`else
  assign gnt = {req[1] & ~req[0], req[0]};
`endif

endmodule

// File: rtl/reg_cmd_arbiter.sv
// rtl/reg_cmd_arbiter.sv - two-requester register command arbiter, one command outstanding (REG_CMD_ARB_RR_EN: round-robin)
module reg_cmd_arbiter
  import reg_cmd_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input logic               clk,
  input logic               rstn,
  reg_cmd_arbiter_if.slave  bus
);

  state_t      state;
  req_t        lat;
  logic        owner;
  logic [2:0]  cnt;
  logic [1:0]  rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  req;
  logic [1:0]  gnt;
  req_t        sel;

  // requests are only offered to the grant logic while idle and out of reset
  assign req = {bus.req1_valid, bus.req0_valid} & {2{(state == ARB) && rstn}};

  reg_cmd_rr_arb u_arb (
`ifdef REG_CMD_ARB_RR_EN
    .clk  (clk),
    .rstn (rstn),
    .take (|gnt),
`endif
    .req  (req),
    .gnt  (gnt)
  );

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];

  assign sel = gnt[1] ? {bus.req1_cmd, bus.req1_addr, bus.req1_wdata}
                      : {bus.req0_cmd, bus.req0_addr, bus.req0_wdata};

  assign bus.cmd        = (state == ISSUE) ? lat.cmd  : IDLE;
  assign bus.cmd_addr   = (state == ISSUE) ? lat.addr : 8'h00;
  assign bus.cmd_data_w = (state == ISSUE && lat.cmd == WR) ? lat.wdata : 32'h0;

  assign bus.rsp0_valid = rsp_valid[0];
  assign bus.rsp1_valid = rsp_valid[1];
  assign bus.rsp0_err   = rsp_valid[0] & rsp_err;
  assign bus.rsp1_err   = rsp_valid[1] & rsp_err;
  assign bus.rsp0_rdata = rsp_valid[0] ? rsp_rdata : 32'h0;
  assign bus.rsp1_rdata = rsp_valid[1] ? rsp_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ARB;
      lat       <= '0;
      owner     <= 1'b0;
      cnt       <= 3'd0;
      rsp_valid <= 2'b00;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      rsp_valid <= 2'b00;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
      case (state)
        ARB: begin
          if (|gnt) begin
            lat   <= sel;
            owner <= gnt[1];
            if (is_bus_cmd(sel.cmd)) begin
              state <= ISSUE;
            end else begin
              rsp_valid <= gnt;
              rsp_err   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (lat.cmd == RD) begin
            state <= WAIT_RD;
            cnt   <= 3'(RD_LAT - 1);
          end else begin
            state     <= ARB;
            rsp_valid <= {owner, ~owner};
          end
        end
        WAIT_RD: begin
          if (cnt == 3'd0) begin
            state     <= ARB;
            rsp_valid <= {owner, ~owner};
            rsp_rdata <= bus.cmd_data_r;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cmd_arbiter.sv
// tb/tb_reg_cmd_arbiter.sv - directed self-checking bench for reg_cmd_arbiter
module tb_reg_cmd_arbiter;
  import reg_cmd_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  reg_cmd_arbiter_if bus ();

  reg_cmd_arbiter #(.RD_LAT(1)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic [1:0] c, input logic [7:0] a, input logic [31:0] d);
    bus.req0_valid = v; bus.req0_cmd = c; bus.req0_addr = a; bus.req0_wdata = d;
  endtask

  task automatic drive1(input logic v, input logic [1:0] c, input logic [7:0] a, input logic [31:0] d);
    bus.req1_valid = v; bus.req1_cmd = c; bus.req1_addr = a; bus.req1_wdata = d;
  endtask

  initial begin
    logic g;
    logic prev;
    drive0(1'b0, IDLE, 8'h00, 32'h0);
    drive1(1'b0, IDLE, 8'h00, 32'h0);
    bus.cmd_data_r = 32'h0;

    // reset, with a request pending that must not be accepted
    step(); step();
    drive0(1'b1, WR, 8'h04, 32'hDEADBEEF);
    #1;
    chk("rst_ready0", {31'h0, bus.req0_ready}, 32'h0);
    chk("rst_rsp0", {31'h0, bus.rsp0_valid}, 32'h0);
    chk("rst_cmd", {30'h0, bus.cmd}, 32'h0);
    chk("rst_addr", {24'h0, bus.cmd_addr}, 32'h0);
    chk("rst_dataw", bus.cmd_data_w, 32'h0);
    step();
    drive0(1'b0, IDLE, 8'h00, 32'h0);
    rstn = 1'b1;

    // contention: both WR held continuously
    step();
    drive0(1'b1, WR, 8'h10, 32'h1000);
    drive1(1'b1, WR, 8'h20, 32'h2000);
    prev = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef REG_CMD_ARB_RR_EN
      g = i[0];
`else
      g = 1'b0;
`endif
      #1;
      chk($sformatf("cont_ready0_%0d", i), {31'h0, bus.req0_ready}, {31'h0, ~g});
      chk($sformatf("cont_ready1_%0d", i), {31'h0, bus.req1_ready}, {31'h0, g});
      if (i > 0) begin
        chk($sformatf("cont_rsp0_%0d", i), {31'h0, bus.rsp0_valid}, {31'h0, ~prev});
        chk($sformatf("cont_rsp1_%0d", i), {31'h0, bus.rsp1_valid}, {31'h0, prev});
      end
      step();
      #1;
      chk($sformatf("cont_cmd_%0d", i), {30'h0, bus.cmd}, {30'h0, WR});
      chk($sformatf("cont_addr_%0d", i), {24'h0, bus.cmd_addr}, g ? 32'h20 : 32'h10);
      prev = g;
      step();
    end
    drive0(1'b0, IDLE, 8'h00, 32'h0);
    drive1(1'b0, IDLE, 8'h00, 32'h0);
    #1;
    chk("cont_last_rsp0", {31'h0, bus.rsp0_valid}, {31'h0, ~prev});
    chk("cont_last_rsp1", {31'h0, bus.rsp1_valid}, {31'h0, prev});
    step();

    // single WR from port 0
    step();
    drive0(1'b1, WR, 8'h04, 32'hDEADBEEF);
    #1;
    chk("wr_ready0", {31'h0, bus.req0_ready}, 32'h1);
    chk("wr_ready1", {31'h0, bus.req1_ready}, 32'h0);
    chk("wr_cmd_T", {30'h0, bus.cmd}, 32'h0);
    step();
    drive0(1'b0, IDLE, 8'h00, 32'h0);
    #1;
    chk("wr_cmd", {30'h0, bus.cmd}, 32'h2);
    chk("wr_addr", {24'h0, bus.cmd_addr}, 32'h04);
    chk("wr_dataw", bus.cmd_data_w, 32'hDEADBEEF);
    chk("wr_rsp_early", {31'h0, bus.rsp0_valid}, 32'h0);
    step();
    #1;
    chk("wr_cmd_T2", {30'h0, bus.cmd}, 32'h0);
    chk("wr_dataw_T2", bus.cmd_data_w, 32'h0);
    chk("wr_rsp0", {31'h0, bus.rsp0_valid}, 32'h1);
    chk("wr_rdata", bus.rsp0_rdata, 32'h0);
    chk("wr_err", {31'h0, bus.rsp0_err}, 32'h0);
    chk("wr_rsp1", {31'h0, bus.rsp1_valid}, 32'h0);
    step();
    #1;
    chk("wr_rsp0_T3", {31'h0, bus.rsp0_valid}, 32'h0);

    // single RD from port 1
    step();
    drive1(1'b1, RD, 8'h08, 32'hFFFFFFFF);
    #1;
    chk("rd_ready1", {31'h0, bus.req1_ready}, 32'h1);
    step();
    drive1(1'b0, IDLE, 8'h00, 32'h0);
    #1;
    chk("rd_cmd", {30'h0, bus.cmd}, 32'h1);
    chk("rd_addr", {24'h0, bus.cmd_addr}, 32'h08);
    chk("rd_dataw", bus.cmd_data_w, 32'h0);
    step();
    bus.cmd_data_r = 32'h12345678;
    #1;
    chk("rd_cmd_T2", {30'h0, bus.cmd}, 32'h0);
    chk("rd_rsp_T2", {31'h0, bus.rsp1_valid}, 32'h0);
    step();
    bus.cmd_data_r = 32'h0;
    #1;
    chk("rd_rsp1", {31'h0, bus.rsp1_valid}, 32'h1);
    chk("rd_rdata", bus.rsp1_rdata, 32'h12345678);
    chk("rd_err", {31'h0, bus.rsp1_err}, 32'h0);
    chk("rd_rsp0", {31'h0, bus.rsp0_valid}, 32'h0);

    // invalid command 11 from port 0
    step();
    drive0(1'b1, 2'b11, 8'h55, 32'h5555);
    #1;
    chk("inv_ready0", {31'h0, bus.req0_ready}, 32'h1);
    chk("inv_cmd_T", {30'h0, bus.cmd}, 32'h0);
    step();
    drive0(1'b0, IDLE, 8'h00, 32'h0);
    #1;
    chk("inv_rsp0", {31'h0, bus.rsp0_valid}, 32'h1);
    chk("inv_err", {31'h0, bus.rsp0_err}, 32'h1);
    chk("inv_rdata", bus.rsp0_rdata, 32'h0);
    chk("inv_cmd_T1", {30'h0, bus.cmd}, 32'h0);
    step();
    #1;
    chk("inv_rsp0_T2", {31'h0, bus.rsp0_valid}, 32'h0);
    chk("inv_cmd_T2", {30'h0, bus.cmd}, 32'h0);

    // reset during WAIT_RD
    step();
    drive0(1'b1, RD, 8'h30, 32'h0);
    #1;
    chk("rrd_ready0", {31'h0, bus.req0_ready}, 32'h1);
    step();
    drive0(1'b0, IDLE, 8'h00, 32'h0);
    #1;
    chk("rrd_cmd", {30'h0, bus.cmd}, 32'h1);
    step();
    rstn = 1'b0;
    bus.cmd_data_r = 32'hAAAA5555;
    step();
    rstn = 1'b1;
    #1;
    chk("rrd_rsp0", {31'h0, bus.rsp0_valid}, 32'h0);
    chk("rrd_rdata0", bus.rsp0_rdata, 32'h0);
    chk("rrd_err0", {31'h0, bus.rsp0_err}, 32'h0);
    chk("rrd_rsp1", {31'h0, bus.rsp1_valid}, 32'h0);
    chk("rrd_cmd", {30'h0, bus.cmd}, 32'h0);
    chk("rrd_addr", {24'h0, bus.cmd_addr}, 32'h0);
    chk("rrd_dataw", bus.cmd_data_w, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      chk($sformatf("rrd_quiet_%0d", i), {30'h0, bus.rsp1_valid, bus.rsp0_valid}, 32'h0);
    end
    bus.cmd_data_r = 32'h0;
    drive1(1'b1, WR, 8'h40, 32'h00000011);
    #1;
    chk("post_ready1", {31'h0, bus.req1_ready}, 32'h1);
    step();
    drive1(1'b0, IDLE, 8'h00, 32'h0);
    #1;
    chk("post_cmd", {30'h0, bus.cmd}, 32'h2);
    chk("post_addr", {24'h0, bus.cmd_addr}, 32'h40);
    chk("post_dataw", bus.cmd_data_w, 32'h11);
    step();
    #1;
    chk("post_rsp1", {31'h0, bus.rsp1_valid}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
